dice_roll_ctrl: RTL and testbench

Sequencer for the dice BCD down-counter. Turns the seven raw die buttons into one arbitrated roll: it selects a die, emits a load strobe, then emits step strobes while the button is held. After release it emits a decelerating run of coast steps and then flags the result as final. It sits between `ui_in` and the counter datapath, which only reacts to `load` and `step`.

---
 rtl/dice_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/dice_roll_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared definitions for the dice roll sequencer: die index constants, the
// roll FSM state encoding and a helper that picks the lowest pressed button.
// -----------------------------------------------------------------------------
package dice_pkg;

  localparam int NUM_DICE = 7;

  localparam logic [2:0] DIE_D4   = 3'd0;
  localparam logic [2:0] DIE_D6   = 3'd1;
  localparam logic [2:0] DIE_D8   = 3'd2;
  localparam logic [2:0] DIE_D10  = 3'd3;
  localparam logic [2:0] DIE_D12  = 3'd4;
  localparam logic [2:0] DIE_D20  = 3'd5;
  localparam logic [2:0] DIE_D100 = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SPIN  = 3'd2,
    COAST = 3'd3,
    SHOW  = 3'd4
  } state_e;

  // Simultaneous presses resolve to the smallest die index.
  function automatic logic [2:0] lowest_set(input logic [NUM_DICE-1:0] b);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_DICE - 1; i >= 0; i--) begin
      if (b[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Single-bit debounce filter. The output follows the input only after the
// input has differed from the output for DB_CYCLES consecutive cycles; any
// shorter excursion is discarded.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  synchronized raw button level
//   q     out debounced level
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 328
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (d != q_q) begin
      // The count restarts whenever the input agrees with the output again.
      if (cnt_q == CW'(DB_CYCLES - 1)) q_d = d;
      else                             cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// -----------------------------------------------------------------------------
// dice_roll_ctrl
// Roll sequencer in front of the dice BCD down-counter. Synchronizes (and
// optionally debounces) the seven die buttons, arbitrates one die, issues a
// load strobe, step strobes while the button is held, then a decelerating
// coast run with doubling intervals, and finally flags the result.
//
// Build option: define DICE_CTRL_DEBOUNCE_EN to insert a btn_debounce filter
// on every synchronized button; otherwise the synchronizer drives the FSM.
//
// Ports:
//   clk          in   system clock (32768 Hz)
//   rst_n        in   asynchronous active-low reset
//   ena          in   enable; low freezes FSM/timers and blanks load/step
//   btn_in[6:0]  in   raw buttons d4,d6,d8,d10,d12,d20,d100 (bit 0..6)
//   die_sel[2:0] out  selected die index, updated at load
//   load         out  one-cycle preset strobe
//   step         out  one-cycle decrement strobe
//   rolling      out  high in LOAD, SPIN and COAST
//   result_valid out  high from end of coast until the next load
// -----------------------------------------------------------------------------
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int DB_CYCLES   = 328,
  parameter int COAST_STEPS = 6,
  parameter int COAST_BASE  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] btn_in,
  output logic [2:0] die_sel,
  output logic       load,
  output logic       step,
  output logic       rolling,
  output logic       result_valid
);

  // Largest interval ever loaded is COAST_BASE << (COAST_STEPS-1).
  localparam int TW = $clog2(COAST_BASE << COAST_STEPS);
  localparam int RW = $clog2(COAST_STEPS + 1);

  if (COAST_STEPS < 1 || DB_CYCLES < 1 ||
      (COAST_BASE & (COAST_BASE - 1)) != 0) begin : g_param_err
    $error("dice_roll_ctrl: illegal parameter combination");
  end

  logic [NUM_DICE-1:0] sync1_q, sync2_q, btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef DICE_CTRL_DEBOUNCE_EN
  for (genvar i = 0; i < NUM_DICE; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sync2_q[i]),
      .q     (btn_q[i])
    );
  end
`else
  assign btn_q = sync2_q;
`endif

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] interval_q, interval_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic          rolling_q, rolling_d;
  logic          rv_q, rv_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (|btn_q) begin
            sel_d   = lowest_set(btn_q);
            state_d = LOAD;
          end
        end
        LOAD: state_d = SPIN;
        SPIN: begin
          if (!btn_q[sel_q]) begin
            state_d     = COAST;
            interval_d  = TW'(COAST_BASE);
            timer_d     = TW'(COAST_BASE);
            remaining_d = RW'(COAST_STEPS);
          end
        end
        COAST: begin
          if (timer_q == TW'(1)) begin
            remaining_d = remaining_q - RW'(1);
            if (remaining_q == RW'(1)) begin
              state_d = SHOW;
            end else begin
              // Interval is only doubled when another step follows, so it
              // stays inside TW bits.
              interval_d = interval_q << 1;
              timer_d    = interval_q << 1;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        SHOW: begin
          if (btn_q == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    rolling_d = (state_d == LOAD) || (state_d == SPIN) || (state_d == COAST);
    if (state_d == SHOW)      rv_d = 1'b1;
    else if (state_d == LOAD) rv_d = 1'b0;
    else                      rv_d = rv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      interval_q  <= '0;
      remaining_q <= '0;
      rolling_q   <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      rolling_q   <= rolling_d;
      rv_q        <= rv_d;
    end
  end

  // Strobes are decoded purely from flops (state, timer, conditioned
  // buttons) so the release cycle itself carries no step; ena blanks them.
  assign load         = ena && (state_q == LOAD);
  assign step         = ena && (((state_q == SPIN) && btn_q[sel_q]) ||
                                ((state_q == COAST) && (timer_q == TW'(1))));
  assign die_sel      = sel_q;
  assign rolling      = rolling_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
module tb_dice_roll_ctrl;

  localparam int BASE  = 64;
  localparam int STEPS = 6;
  localparam int DB    = 8;
`ifdef DICE_CTRL_DEBOUNCE_EN
  localparam int D = DB;
`else
  localparam int D = 0;
`endif
  localparam int HMIN = 2 + D;

  localparam int K_LOAD = 0;
  localparam int K_STEP = 1;
  localparam int K_RV   = 2;

  typedef struct {
    int kind;
    int cyc;
    int die;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [6:0] btn_in = '0;
  logic [2:0] die_sel;
  logic       load, step, rolling, result_valid;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  load_cnt = 0;
  bit  rv_exp = 0;
  bit  rv_prev = 0;
  ev_t exp_q[$];

  dice_roll_ctrl #(
    .DB_CYCLES   (DB),
    .COAST_STEPS (STEPS),
    .COAST_BASE  (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_in       (btn_in),
    .die_sel      (die_sel),
    .load         (load),
    .step         (step),
    .rolling      (rolling),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input int d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.die  = d;
    exp_q.push_back(e);
  endtask

  // Pop the next expected event and compare it with what the DUT shows now.
  task automatic match(input int kind);
    ev_t e;
    checks++;
    if (kind == K_LOAD) load_cnt++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == K_LOAD && (int'(die_sel) != e.die || result_valid || !rolling)) ||
          (kind == K_RV && rolling)) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d die=%0d rv=%0b roll=%0b exp kind=%0d cyc=%0d die=%0d",
                 kind, cyc, die_sel, result_valid, rolling, e.kind, e.cyc, e.die);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, decoupled from stimulus.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev = 0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_event kind=%0d exp_cyc=%0d now=%0d",
                   exp_q[0].kind, exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (load && step) begin
          checks++;
          errors++;
          $display("FAIL load_and_step both high cycle=%0d", cyc);
        end
        if (load) match(K_LOAD);
        if (step) match(K_STEP);
        if (result_valid && !rv_prev) match(K_RV);
        rv_prev = result_valid;
      end
    end
  end

  // One roll. Offsets cs/eo/ra are relative to R, the release cycle as seen
  // after conditioning; negative eo/ra disables the ena gap / reset.
  task automatic roll(input logic [6:0] m0, input int hold,
                      input logic [6:0] xm, input int xs, input int xl,
                      input logic [6:0] cm, input int cs, input int cl,
                      input int eo, input int el, input int ra);
    int t0, n, r, tk, rv_t, end_t, die;
    bit after_rst;
    logic [6:0] b;
    @(posedge clk); #1;
    t0 = cyc;
    if (rv_exp) chk("rv_held", int'(result_valid), 1);
    die = 0;
    for (int i = 6; i >= 0; i--) if (m0[i]) die = i;
    n = t0 + 3 + D;
    r = t0 + hold + 2 + D;
    push(K_LOAD, n, die);
    for (int c = n + 1; c < r; c++) push(K_STEP, c, 0);
    tk = r;
    for (int k = 1; k <= STEPS; k++) begin
      tk = r + BASE * ((1 << k) - 1);
      if (eo >= 0 && tk >= r + eo) tk += el;
      if (ra < 0 || tk < r + ra) push(K_STEP, tk, 0);
    end
    rv_t = tk + 1;
    if (ra < 0) push(K_RV, rv_t, 0);
    if (ra >= 0) end_t = r + ra + BASE * (1 << STEPS) + 10;
    else         end_t = ((rv_t > r + cs + cl) ? rv_t : r + cs + cl) + 6 + D;
    after_rst = 0;
    for (int t = t0; t <= end_t; t++) begin
      if (t != t0) begin @(posedge clk); #1; end
      b = '0;
      if (!after_rst) begin
        if (t - t0 < hold) begin
          b = m0;
          if (t - t0 >= xs && t - t0 < xs + xl) b = b | xm;
        end
        if (t - r >= cs && t - r < cs + cl) b = b | cm;
      end
      btn_in = b;
      ena = !(eo >= 0 && t - r >= eo && t - r < eo + el);
      if (ra >= 0 && t == r + ra) begin
        rst_n = 0;
        after_rst = 1;
        #1;
        chk("rst_load", int'(load), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_rolling", int'(rolling), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_die", int'(die_sel), 0);
      end
      if (ra >= 0 && t == r + ra + 3) rst_n = 1;
    end
    ena = 1;
    btn_in = '0;
    rv_exp = (ra < 0);
  endtask

  initial begin
    logic [6:0] m, xm, cm;
    int hold, xs, xl, cs, cl, eo, el, lc;
    repeat (3) @(posedge clk);
    #1;
    chk("init_load", int'(load), 0);
    chk("init_step", int'(step), 0);
    chk("init_rolling", int'(rolling), 0);
    chk("init_rv", int'(result_valid), 0);
    chk("init_die", int'(die_sel), 0);
    rst_n = 1;
    repeat (3) @(posedge clk);

    // d8 held 100 cycles, full default coast.
    roll(7'h04, 100, 7'h00, 0, 0, 7'h00, 0, 0, -1, 0, -1);
    // d20+d6 together; d4 mid-spin; d6 re-press during coast.
    roll(7'h22, 60, 7'h01, 20, 15, 7'h02, 10, 20, -1, 0, -1);
    // d12 roll with d100 pressed late in coast and held through SHOW.
    roll(7'h10, 30, 7'h00, 0, 0, 7'h40, 4000, 133, -1, 0, -1);
    // d20 roll with reset mid-coast, then no activity.
    roll(7'h20, 40, 7'h00, 0, 0, 7'h00, 0, 0, -1, 0, 100);
    // d10 roll with a 50-cycle enable gap mid-coast.
    roll(7'h08, 25, 7'h00, 0, 0, 7'h00, 0, 0, 100, 50, -1);

    // Randomized rolls.
    for (int i = 0; i < 4; i++) begin
      m    = 7'($urandom_range(1, 127));
      hold = $urandom_range(HMIN, 60);
      xm   = 7'($urandom_range(0, 127));
      xs   = 4;
      xl   = (hold > 6) ? $urandom_range(1, hold - 5) : 0;
      cm   = 7'($urandom_range(0, 127));
      cs   = $urandom_range(0, 40);
      cl   = $urandom_range(1, 20);
      if ($urandom_range(0, 1) == 1) begin
        eo = $urandom_range(1, 3000);
        el = $urandom_range(1, 60);
      end else begin
        eo = -1;
        el = 0;
      end
      roll(m, hold, xm, xs, xl, cm, cs, cl, eo, el, -1);
    end

`ifdef DICE_CTRL_DEBOUNCE_EN
    // A glitch shorter than the debounce window must not start a roll.
    @(posedge clk); #1;
    lc = load_cnt;
    btn_in = 7'h08;
    repeat (5) @(posedge clk);
    #1;
    btn_in = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_no_load", load_cnt, lc);
    roll(7'h08, 20, 7'h00, 0, 0, 7'h00, 0, 0, -1, 0, -1);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
